// File: rtl/cnn_pkg.sv
// Constants and window indexing helpers shared by the window generator and
// the convolution datapath that consumes its windows.
package cnn_pkg;

    localparam int unsigned DEF_KERNEL = 3;
    localparam int unsigned DEF_N      = 4;
    localparam int unsigned WIN_W      = DEF_KERNEL * DEF_KERNEL * DEF_N;

    // Window element (r, c) lives at bits [win_idx(r, c, k)*N +: N].
    function automatic int unsigned win_idx(input int unsigned r,
                                            input int unsigned c,
                                            input int unsigned k);
        return r * k + c;
    endfunction

    function automatic int unsigned win_width(input int unsigned k,
                                              input int unsigned n);
        return k * k * n;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Single image-row delay: the output is the pixel accepted IMG_W enables ago,
// i.e. the same column one row up. Contents are never cleared.
module conv_line_buffer
    import cnn_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned IMG_W = 8
) (
    input  logic         clk,
    input  logic         en_i,
    input  logic [N-1:0] din_i,
    output logic [N-1:0] dout_o
);

    logic [N-1:0] sr_q [IMG_W];

    always_ff @(posedge clk) begin
        if (en_i) begin
            sr_q[0] <= din_i;
            for (int unsigned i = 1; i < IMG_W; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign dout_o = sr_q[IMG_W-1];

endmodule

// File: rtl/conv_window_gen.sv
// Sliding KERNEL x KERNEL window generator over a raster pixel stream, with
// frame position tracking, validity gating and end-of-frame pulse.
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter int unsigned KERNEL = DEF_KERNEL,
    parameter int unsigned N      = DEF_N,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N-1:0]                      pix_in,
    input  logic                              en_in,
    input  logic                              sof,
    output logic [win_width(KERNEL, N)-1:0]   data2conv,
    output logic                              en_out,
    output logic                              frame_done
);

    localparam int unsigned WW = win_width(KERNEL, N);
    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          win_vld, last_pix;
    logic          en_out_q, done_q;
    logic [WW-1:0] data_q, win_d;
    logic [N-1:0]  tap [KERNEL];

    // sof overrides the counters so the current pixel is taken as (0,0).
    always_comb begin
        cur_col  = sof ? '0 : col_q;
        cur_row  = sof ? '0 : row_q;
        col_d    = col_q;
        row_d    = row_q;
        if (en_in) begin
            if (cur_col == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end
        win_vld  = en_in && (cur_row >= RW'(KERNEL - 1)) && (cur_col >= CW'(KERNEL - 1));
        last_pix = en_in && (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q    <= '0;
            col_q    <= '0;
            en_out_q <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            row_q    <= row_d;
            col_q    <= col_d;
            en_out_q <= win_vld;
            done_q   <= last_pix;
            if (win_vld) begin
                data_q <= win_d;
            end
        end
    end

    assign tap[KERNEL-1] = pix_in;

    if (KERNEL > 1) begin : g_win
        // tap[r] is column cur_col of window row r; row KERNEL-1 is the live pixel.
        for (genvar j = 0; j < KERNEL - 1; j++) begin : g_lb
            conv_line_buffer #(.N(N), .IMG_W(IMG_W)) u_lb (
                .clk    (clk),
                .en_i   (en_in),
                .din_i  (tap[KERNEL-1-j]),
                .dout_o (tap[KERNEL-2-j])
            );
        end

        logic [N-1:0] hist_q [KERNEL][KERNEL-1];

        always_ff @(posedge clk) begin
            if (en_in) begin
                for (int unsigned r = 0; r < KERNEL; r++) begin
                    for (int unsigned c = 0; c + 1 < KERNEL - 1; c++) begin
                        hist_q[r][c] <= hist_q[r][c+1];
                    end
                    hist_q[r][KERNEL-2] <= tap[r];
                end
            end
        end

        always_comb begin
            win_d = '0;
            for (int unsigned r = 0; r < KERNEL; r++) begin
                for (int unsigned c = 0; c < KERNEL - 1; c++) begin
                    win_d[win_idx(r, c, KERNEL)*N +: N] = hist_q[r][c];
                end
                win_d[win_idx(r, KERNEL - 1, KERNEL)*N +: N] = tap[r];
            end
        end
    end else begin : g_pass
        assign win_d = pix_in;
    end

    assign data2conv  = data_q;
    assign en_out     = en_out_q;
    assign frame_done = done_q;

endmodule
